// File: rtl/dram_cmd_sched_if.sv
// Request-queue head and DRAM command bus between the memory queue and dram_cmd_sched.
// The master drives the queue head; the slave (scheduler) pops it and issues commands.
interface dram_cmd_sched_if #(
    parameter int TIME_W = 64
);
    logic              q_valid;
    logic [TIME_W-1:0] q_time;
    logic [31:0]       q_opcode;
    logic [31:0]       q_addr;
    logic              q_pop;
    logic              cmd_valid;
    logic [2:0]        cmd_code;
    logic [1:0]        cmd_bg;
    logic [1:0]        cmd_bank;
    logic [14:0]       cmd_row;
    logic [9:0]        cmd_col;
    logic [TIME_W-1:0] cmd_time;
    logic              busy;
    logic              err_op;

    modport master (
        output q_valid, q_time, q_opcode, q_addr,
        input  q_pop, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
               cmd_time, busy, err_op
    );

    modport slave (
        input  q_valid, q_time, q_opcode, q_addr,
        output q_pop, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
               cmd_time, busy, err_op
    );
endinterface

// File: rtl/dram_cmd_sched.sv
// Closed-page DRAM command generator: ACT, RD/WR, PRE per queued request with
// tRCD/tRAS/tRTP/write-recovery/tRP spacing, one request in flight at a time.
module dram_cmd_sched #(
    parameter int TIME_W  = 64,
    parameter int T_RCD   = 24,
    parameter int T_RAS   = 52,
    parameter int T_RTP   = 12,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4,
    parameter int T_WR    = 20,
    parameter int T_RP    = 24
) (
    input logic               clk,
    input logic               rst_n,
    dram_cmd_sched_if.slave   bus
);

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;

    // PRE spacing is measured from the column command; ACT->PRE folds in as T_RAS-T_RCD.
    localparam int RAS_AFTER_COL = T_RAS - T_RCD;
    localparam int WR_RECOVERY   = T_CWL + T_BURST + T_WR;
    localparam int RD_PRE_DLY    = (RAS_AFTER_COL > T_RTP) ? RAS_AFTER_COL : T_RTP;
    localparam int WR_PRE_DLY    = (RAS_AFTER_COL > WR_RECOVERY) ? RAS_AFTER_COL : WR_RECOVERY;

    // Counters are loaded with delay-1 so the command fires exactly 'delay' edges later.
    localparam logic [7:0] RCD_LD    = 8'(T_RCD - 1);
    localparam logic [7:0] RD_PRE_LD = 8'(RD_PRE_DLY - 1);
    localparam logic [7:0] WR_PRE_LD = 8'(WR_PRE_DLY - 1);
    localparam logic [7:0] RP_LD     = 8'(T_RP - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACT_WAIT = 3'd1,
        COL_WAIT = 3'd2,
        PRE_WAIT = 3'd3,
        RP_WAIT  = 3'd4
    } state_t;

    state_t            state_r;
    logic [7:0]        cnt_r;
    logic [TIME_W-1:0] cycle_ct_r;
    logic              is_wr_r;

    logic              q_pop_r;
    logic              cmd_valid_r;
    logic [2:0]        cmd_code_r;
    logic [1:0]        cmd_bg_r;
    logic [1:0]        cmd_bank_r;
    logic [14:0]       cmd_row_r;
    logic [9:0]        cmd_col_r;
    logic [TIME_W-1:0] cmd_time_r;
    logic              busy_r;
    logic              err_op_r;

    logic              accept_s;
    logic              start_s;
    logic              legal_s;
    logic              addr_unused_s;

    assign accept_s = bus.q_valid && (cycle_ct_r >= bus.q_time);
    // A new request may also start on the very edge tRP expires.
    assign start_s  = accept_s && ((state_r == IDLE) ||
                                   ((state_r == RP_WAIT) && (cnt_r == 8'd0)));
    assign legal_s  = (bus.q_opcode <= 32'd2);
    assign addr_unused_s = ^bus.q_addr[2:0];

    // Sequencer: state, wait counter, free-running cycle counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            cycle_ct_r  <= '0;
            is_wr_r     <= 1'b0;
            q_pop_r     <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= CMD_NONE;
            cmd_bg_r    <= 2'd0;
            cmd_bank_r  <= 2'd0;
            cmd_row_r   <= 15'd0;
            cmd_col_r   <= 10'd0;
            cmd_time_r  <= '0;
            busy_r      <= 1'b0;
            err_op_r    <= 1'b0;
        end else begin
            cycle_ct_r  <= cycle_ct_r + TIME_W'(1);
            q_pop_r     <= 1'b0;
            err_op_r    <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= CMD_NONE;

            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                ACT_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_r     <= COL_WAIT;
                        cnt_r       <= is_wr_r ? WR_PRE_LD : RD_PRE_LD;
                        cmd_valid_r <= 1'b1;
                        cmd_code_r  <= is_wr_r ? CMD_WR : CMD_RD;
                        cmd_time_r  <= cycle_ct_r + TIME_W'(1);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                COL_WAIT, PRE_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_r     <= RP_WAIT;
                        cnt_r       <= RP_LD;
                        cmd_valid_r <= 1'b1;
                        cmd_code_r  <= CMD_PRE;
                        cmd_time_r  <= cycle_ct_r + TIME_W'(1);
                    end else begin
                        state_r <= PRE_WAIT;
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                RP_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            // Acceptance overrides the case above, including the tRP-expiry edge.
            if (start_s) begin
                q_pop_r <= 1'b1;
                if (legal_s) begin
                    state_r     <= ACT_WAIT;
                    cnt_r       <= RCD_LD;
                    busy_r      <= 1'b1;
                    is_wr_r     <= (bus.q_opcode == 32'd1);
                    cmd_col_r   <= bus.q_addr[12:3];
                    cmd_bank_r  <= bus.q_addr[14:13];
                    cmd_bg_r    <= bus.q_addr[16:15];
                    cmd_row_r   <= bus.q_addr[31:17];
                    cmd_valid_r <= 1'b1;
                    cmd_code_r  <= CMD_ACT;
                    cmd_time_r  <= cycle_ct_r + TIME_W'(1);
                end else begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    err_op_r <= 1'b1;
                end
            end else begin
                q_pop_r <= 1'b0;
            end
        end
    end

    assign bus.q_pop     = q_pop_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_code  = cmd_code_r;
    assign bus.cmd_bg    = cmd_bg_r;
    assign bus.cmd_bank  = cmd_bank_r;
    assign bus.cmd_row   = cmd_row_r;
    assign bus.cmd_col   = cmd_col_r;
    assign bus.cmd_time  = cmd_time_r;
    assign bus.busy      = busy_r;
    assign bus.err_op    = err_op_r;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Scoreboard bench for dram_cmd_sched: a queue-head model feeds requests, expected
// commands are queued up front and checked as the scheduler issues them.
module tb_dram_cmd_sched;

    typedef struct packed {
        logic [63:0] t;
        logic [31:0] op;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic [2:0]  code;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [9:0]  col;
        logic [63:0] t;
    } cmd_t;

    logic clk;
    logic rst_n;

    dram_cmd_sched_if #(.TIME_W(64)) bus ();

    dram_cmd_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    req_t req_q[$];
    cmd_t exp_q[$];
    int   n_cmp;
    int   n_fail;
    int   tb_cyc;
    int   pop_cnt;
    int   first_pop;
    int   last_pop;
    int   err_cnt;
    int   err_cyc;
    int   busy_fall;
    logic busy_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_head();
        if (req_q.size() > 0) begin
            bus.q_valid  = 1'b1;
            bus.q_time   = req_q[0].t;
            bus.q_opcode = req_q[0].op;
            bus.q_addr   = req_q[0].addr;
        end else begin
            bus.q_valid  = 1'b0;
            bus.q_time   = 64'd0;
            bus.q_opcode = 32'd0;
            bus.q_addr   = 32'd0;
        end
    endtask

    task automatic push_req(input longint t, input int op, input logic [31:0] addr);
        req_t r;
        r.t = 64'(t);
        r.op = 32'(op);
        r.addr = addr;
        req_q.push_back(r);
        drive_head();
    endtask

    task automatic push_cmd(input int code, input logic [31:0] addr, input longint t);
        cmd_t c;
        logic [31:0] a;
        a = addr;
        c.code = 3'(code);
        c.col  = a[12:3];
        c.bank = a[14:13];
        c.bg   = a[16:15];
        c.row  = a[31:17];
        c.t    = 64'(t);
        exp_q.push_back(c);
    endtask

    // One clock: sample at the falling edge, retire popped heads, score issued commands.
    task automatic tick();
        cmd_t e;
        @(negedge clk);
        tb_cyc++;
        if (bus.q_pop === 1'b1) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = tb_cyc;
            last_pop = tb_cyc;
            if (req_q.size() > 0) void'(req_q.pop_front());
        end
        if (bus.cmd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cmd cyc=%0d got code=%0d t=%0d, required no command",
                         tb_cyc, bus.cmd_code, bus.cmd_time);
            end else begin
                e = exp_q.pop_front();
                if ({bus.cmd_code, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_time}
                    !== {e.code, e.bg, e.bank, e.row, e.col, e.t}) begin
                    n_fail++;
                    $display("FAIL cmd cyc=%0d got code=%0d bg=%0d bank=%0d row=%h col=%h t=%0d, required code=%0d bg=%0d bank=%0d row=%h col=%h t=%0d",
                             tb_cyc, bus.cmd_code, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col,
                             bus.cmd_time, e.code, e.bg, e.bank, e.row, e.col, e.t);
                end
            end
        end else if (bus.cmd_code !== 3'd0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_code_idle cyc=%0d got %0d, required 0", tb_cyc, bus.cmd_code);
        end
        if (bus.err_op === 1'b1) begin
            err_cnt++;
            err_cyc = tb_cyc;
        end
        if (busy_prev === 1'b1 && bus.busy === 1'b0 && busy_fall < 0) busy_fall = tb_cyc;
        busy_prev = bus.busy;
        drive_head();
    endtask

    task automatic clear_stats();
        tb_cyc    = 0;
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
        err_cnt   = 0;
        err_cyc   = -1;
        busy_fall = -1;
        busy_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_q.delete();
        exp_q.delete();
        drive_head();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({bus.q_pop, bus.cmd_valid, bus.cmd_code, bus.cmd_bg, bus.cmd_bank, bus.cmd_row,
             bus.cmd_col, bus.cmd_time, bus.busy, bus.err_op} !== 101'd0) begin
            n_fail++;
            $display("FAIL %s got pop=%b v=%b code=%0d t=%0d busy=%b err=%b, required all 0",
                     name, bus.q_pop, bus.cmd_valid, bus.cmd_code, bus.cmd_time, bus.busy, bus.err_op);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_head();
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        clear_stats();
        check_all_zero("reset_released");
        repeat (6) tick();
        check_int("reset_no_pop", pop_cnt, 0);
        check_all_zero("reset_idle_quiet");
    endtask

    task automatic test_read();
        do_reset();
        push_req(10, 0, 32'h0002_A048);
        push_cmd(1, 32'h0002_A048, 11);
        push_cmd(2, 32'h0002_A048, 35);
        push_cmd(4, 32'h0002_A048, 63);
        repeat (95) tick();
        check_int("read_pop_cnt", pop_cnt, 1);
        check_int("read_pop_cyc", first_pop, 11);
        check_int("read_busy_fall", busy_fall, 87);
        check_int("read_cmds_left", exp_q.size(), 0);
    endtask

    task automatic test_write();
        do_reset();
        push_req(10, 1, 32'h0002_A048);
        push_cmd(1, 32'h0002_A048, 11);
        push_cmd(3, 32'h0002_A048, 35);
        push_cmd(4, 32'h0002_A048, 79);
        repeat (110) tick();
        check_int("write_pop_cnt", pop_cnt, 1);
        check_int("write_busy_fall", busy_fall, 103);
        check_int("write_cmds_left", exp_q.size(), 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_req(0, 0, 32'h0002_A048);
        push_req(0, 2, 32'hFFFF_FFFF);
        push_cmd(1, 32'h0002_A048, 1);
        push_cmd(2, 32'h0002_A048, 25);
        push_cmd(4, 32'h0002_A048, 53);
        push_cmd(1, 32'hFFFF_FFFF, 77);
        push_cmd(2, 32'hFFFF_FFFF, 101);
        push_cmd(4, 32'hFFFF_FFFF, 129);
        repeat (160) tick();
        check_int("b2b_pop_cnt", pop_cnt, 2);
        check_int("b2b_first_pop", first_pop, 1);
        check_int("b2b_second_pop", last_pop, 77);
        check_int("b2b_busy_fall", busy_fall, 153);
        check_int("b2b_cmds_left", exp_q.size(), 0);
    endtask

    task automatic test_illegal_op();
        do_reset();
        push_req(5, 7, 32'h1234_5678);
        push_req(0, 0, 32'h0002_A048);
        push_cmd(1, 32'h0002_A048, 7);
        push_cmd(2, 32'h0002_A048, 31);
        push_cmd(4, 32'h0002_A048, 59);
        repeat (6) tick();
        check_int("illegal_busy_at_err", bus.busy, 0);
        repeat (84) tick();
        check_int("illegal_err_cnt", err_cnt, 1);
        check_int("illegal_err_cyc", err_cyc, 6);
        check_int("illegal_first_pop", first_pop, 6);
        check_int("illegal_next_pop", last_pop, 7);
        check_int("illegal_pop_cnt", pop_cnt, 2);
        check_int("illegal_busy_fall", busy_fall, 83);
        check_int("illegal_cmds_left", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_req(10, 0, 32'h0002_A048);
        push_cmd(1, 32'h0002_A048, 11);
        push_cmd(2, 32'h0002_A048, 35);
        push_cmd(4, 32'h0002_A048, 63);
        repeat (40) tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset_outputs");
        check_int("midreset_pending", exp_q.size(), 1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        clear_stats();
        push_req(3, 0, 32'hFFFF_FFFF);
        push_cmd(1, 32'hFFFF_FFFF, 4);
        push_cmd(2, 32'hFFFF_FFFF, 28);
        push_cmd(4, 32'hFFFF_FFFF, 56);
        repeat (90) tick();
        check_int("midreset_pop_cnt", pop_cnt, 1);
        check_int("midreset_busy_fall", busy_fall, 80);
        check_int("midreset_cmds_left", exp_q.size(), 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_stats();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_illegal_op();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
